sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It is the same-clock successor to the team's dual-clock FIFO, for datapaths where producer and consumer share one clock. It adds a fill-level count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a build-time choice between a registered read port and a first-word-fall-through (FWFT) read port. It sits between pipeline stages and carries buffering, back-pressure and rate smoothing.

Parameters:
DATA_WIDTH, 8, width of each data word.
DEPTH, 8, number of entries; must be a power of two and at least 2.
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
PTR_WIDTH, $clog2(DEPTH), derived; not to be overridden.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset, sampled on the clk rising edge.
w_en  in  1  write request.
data_in  in  DATA_WIDTH  write data.
r_en  in  1  read request; in FWFT mode this is the pop/acknowledge.
data_out  out  DATA_WIDTH  read data.
rd_valid  out  1  data_out is valid.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  one-cycle pulse on a rejected write.
underflow  out  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset (rst_n low at an edge):
  - Pointers and count go to 0.
  - Reset output values: empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0 (FWFT=0), data_out=0 (FWFT=0).
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data. Requests present in the reset cycle are ignored and produce no error pulses.
- Pointers:
  - wptr and rptr are PTR_WIDTH+1 bits wide; the low PTR_WIDTH bits address memory.
  - Binary increment, natural wrap; no Gray code is needed because there is one clock.
- Acceptance rules, evaluated on registered state:
  - rd_ok = r_en & !empty.
  - wr_ok = w_en & (!full | rd_ok). A write on a full FIFO is accepted when a read is accepted in the same cycle.
  - A read on an empty FIFO is always rejected, even if a write happens in the same cycle; there is no write-to-read bypass.
- Count update:
  - +1 on wr_ok & !rd_ok.
  - -1 on rd_ok & !wr_ok.
  - Unchanged otherwise.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count only. They are glitch-free and reflect the state after the most recent edge.
- Errors:
  - overflow is registered; it is 1 in the cycle after an edge where w_en & !wr_ok.
  - underflow is registered; it is 1 in the cycle after an edge where r_en & !rd_ok.
- FWFT=0 (registered read):
  - On rd_ok, data_out <= mem[rptr] at the edge, and rd_valid=1 for the following cycle only.
  - data_out holds its value when there is no read.
  - Read latency is 1 cycle.
- FWFT=1 (fall-through):
  - data_out = mem[rptr] combinationally, and rd_valid = !empty.
  - r_en acknowledges the word being displayed.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Memory write: mem[wptr] <= data_in on wr_ok.
- Wrap-around: after 2*DEPTH accepted writes, wptr returns to 0. Count stays correct across wraps.

Decomposition:
- A shared package, fifo_pkg, holds:
  - a function that checks DEPTH is a power of two;
  - a default threshold constant;
  - the enum FWFT_OFF=0 / FWFT_ON=1.
- Add an elaboration-time check that DEPTH is a power of two and both thresholds are in range.
- One sub-module, sync_fifo_ram: a single-clock memory with synchronous write and asynchronous read. The top-level module registers the read data when FWFT=0.

Test Plan (DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2 unless stated):
1. Reset → empty=1, almost_empty=1, count=0, full=0, rd_valid=0. Then 8 writes of 0x10..0x17 → count goes 1..8; almost_full asserts at count 6; full asserts after the 8th edge; a 9th write gives overflow=1 for one cycle and count stays 8.
2. From full with FWFT=0: 8 back-to-back reads → data_out 0x10..0x17, each with rd_valid one cycle after its r_en; empty after the 8th read; an extra read gives underflow=1 and rd_valid=0.
3. Simultaneous w_en and r_en at count=8 → write accepted, count stays 8, no overflow. At count=0 → read rejected with underflow=1, write accepted, count becomes 1.
4. Wrap: 20 write/read pairs with random data → every read matches scoreboard order; count never exceeds 8.
5. FWFT=1: write 0xA5 into an empty FIFO → next cycle data_out=0xA5 and rd_valid=1 with no r_en; assert r_en → empty=1 and rd_valid=0 next cycle.
6. Reset asserted at count=5 in mid-stream → next cycle count=0 and empty=1; the stale word is never delivered; no error pulses occur during reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Definitions shared by the single-clock FIFO and its memory:
//   - fwft_mode_e      : read-port style (registered or fall-through)
//   - DEFAULT_AE_LEVEL : default almost-empty threshold
//   - is_pow2()        : depth legality check used at elaboration
package fifo_pkg;

  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } fwft_mode_e;

  localparam int DEFAULT_AE_LEVEL = 2;

  // A depth is legal when it is at least 2 and has a single bit set.
  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
//   Single-clock storage array: synchronous write, asynchronous read.
//   The array is not reset.
//   Ports:
//     clk      : clock, rising edge
//     we_i     : write enable
//     waddr_i  : write address
//     wdata_i  : write data
//     raddr_i  : read address
//     rdata_o  : read data, combinational from raddr_i
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock FIFO with fill-level count, almost-full/almost-empty
//   thresholds, overflow/underflow pulses and a build-time choice of
//   registered (FWFT=0) or first-word-fall-through (FWFT=1) read port.
//   Ports:
//     clk          : clock, rising edge
//     rst_n        : synchronous active-low reset
//     w_en         : write request
//     data_in      : write data
//     r_en         : read request (pop/acknowledge in FWFT mode)
//     data_out     : read data
//     rd_valid     : data_out is valid
//     full / empty : count == DEPTH / count == 0
//     almost_full  : count >= AF_LEVEL
//     almost_empty : count <= AE_LEVEL
//     count        : occupancy 0..DEPTH
//     overflow     : one-cycle pulse after a rejected write
//     underflow    : one-cycle pulse after a rejected read
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL,
  parameter int FWFT       = int'(FWFT_OFF),
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end
  if (FWFT != int'(FWFT_OFF) && FWFT != int'(FWFT_ON)) begin : g_bad_fwft
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [PTR_WIDTH:0] ONE_C   = (PTR_WIDTH + 1)'(1);

  logic [PTR_WIDTH:0]    wptr_q, wptr_d;
  logic [PTR_WIDTH:0]    rptr_q, rptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags decode the registered count only, so they never glitch.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is fine when a read frees a slot in the same
  // cycle. The converse does not hold: no write-to-read bypass when empty.
  assign rd_ok = r_en & ~empty;
  assign wr_ok = w_en & (~full | rd_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + ONE_C;
    if (rd_ok) rptr_d = rptr_q + ONE_C;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= w_en & ~wr_ok;
      underflow_q <= r_en & ~rd_ok;
    end
  end

  // Gating with rst_n keeps a write presented during reset out of the array.
  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_ok & rst_n),
    .waddr_i (wptr_q[PTR_WIDTH-1:0]),
    .wdata_i (data_in),
    .raddr_i (rptr_q[PTR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  if (FWFT == int'(FWFT_ON)) begin : g_fwft
    // Head word is shown directly; r_en acknowledges it.
    assign data_out = ram_rdata;
    assign rd_valid = ~empty;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) data_q <= ram_rdata;
      end
    end

    assign data_out = data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one fall-through
// instance share the same stimulus and are checked against a queue model.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] dout_r, dout_f;
  logic          rv_r, rv_f, full_r, full_f, empty_r, empty_f;
  logic          af_r, af_f, ae_r, ae_f, ovf_r, ovf_f, unf_r, unf_f;
  logic [3:0]    cnt_r, cnt_f;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout_r), .rd_valid(rv_r), .full(full_r), .empty(empty_r),
    .almost_full(af_r), .almost_empty(ae_r), .count(cnt_r),
    .overflow(ovf_r), .underflow(unf_r)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fw (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout_f), .rd_valid(rv_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(cnt_f),
    .overflow(ovf_f), .underflow(unf_f)
  );

  typedef struct {
    bit            w;
    bit            r;
    logic [DW-1:0] d;
    int            cnt;
    bit            ovf;
    bit            unf;
    bit            rv;
    logic [DW-1:0] dout;
  } vec_t;

  localparam int NVEC = 28;
  vec_t tbl[NVEC];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input bit w, input bit r, input logic [DW-1:0] d,
                         input int cnt, input bit ovf, input bit unf, input bit rv,
                         input logic [DW-1:0] dout);
    tbl[i].w = w; tbl[i].r = r; tbl[i].d = d; tbl[i].cnt = cnt;
    tbl[i].ovf = ovf; tbl[i].unf = unf; tbl[i].rv = rv; tbl[i].dout = dout;
  endtask

  // One clock cycle: update the model from the stimulus, drive, then check
  // every output of both instances one time unit after the edge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r);
    bit m_rd, m_wr;
    int sz;
    m_rd = r && (model_q.size() != 0);
    m_wr = w && ((model_q.size() != DEPTH) || m_rd);
    if (m_rd) exp_q.push_back(model_q.pop_front());
    if (m_wr) model_q.push_back(d);
    w_en = w; data_in = d; r_en = r;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0;
    sz = model_q.size();
    chk("count", int'(cnt_r), sz);
    chk("empty", int'(empty_r), int'(sz == 0));
    chk("full", int'(full_r), int'(sz == DEPTH));
    chk("almost_full", int'(af_r), int'(sz >= AF));
    chk("almost_empty", int'(ae_r), int'(sz <= AE));
    chk("overflow", int'(ovf_r), int'(w && !m_wr));
    chk("underflow", int'(unf_r), int'(r && !m_rd));
    chk("rd_valid", int'(rv_r), int'(m_rd));
    if (rv_r) begin
      if (exp_q.size() == 0) chk("scoreboard_nonempty", 0, 1);
      else chk("data_out", int'(dout_r), int'(exp_q.pop_front()));
    end
    chk("fw_count", int'(cnt_f), sz);
    chk("fw_overflow", int'(ovf_f), int'(w && !m_wr));
    chk("fw_underflow", int'(unf_f), int'(r && !m_rd));
    chk("fw_rd_valid", int'(rv_f), int'(sz != 0));
    if (sz != 0) chk("fw_data_out", int'(dout_f), int'(model_q[0]));
  endtask

  task automatic do_reset(input bit w, input bit r);
    rst_n = 1'b0; w_en = w; r_en = r; data_in = 8'hEE;
    @(posedge clk); #1;
    rst_n = 1'b1; w_en = 1'b0; r_en = 1'b0;
    model_q.delete();
    exp_q.delete();
    chk("rst_count", int'(cnt_r), 0);
    chk("rst_empty", int'(empty_r), 1);
    chk("rst_almost_empty", int'(ae_r), 1);
    chk("rst_full", int'(full_r), 0);
    chk("rst_almost_full", int'(af_r), 0);
    chk("rst_overflow", int'(ovf_r), 0);
    chk("rst_underflow", int'(unf_r), 0);
    chk("rst_rd_valid", int'(rv_r), 0);
    chk("rst_data_out", int'(dout_r), 0);
    chk("rst_fw_rd_valid", int'(rv_f), 0);
    chk("rst_fw_overflow", int'(ovf_f), 0);
    chk("rst_fw_underflow", int'(unf_f), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill, overflow, drain, underflow, simultaneous ops at both limits.
    for (int i = 0; i < 8; i++) set_vec(i, 1, 0, 8'(8'h10 + i), i + 1, 0, 0, 0, 8'h00);
    set_vec(8, 1, 0, 8'h99, 8, 1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) set_vec(9 + i, 0, 1, 8'h00, 7 - i, 0, 0, 1, 8'(8'h10 + i));
    set_vec(17, 0, 1, 8'h00, 0, 0, 1, 0, 8'h00);
    set_vec(18, 1, 1, 8'h30, 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 7; i++) set_vec(19 + i, 1, 0, 8'(8'h31 + i), i + 2, 0, 0, 0, 8'h00);
    set_vec(26, 1, 1, 8'h38, 8, 0, 0, 1, 8'h30);
    set_vec(27, 0, 0, 8'h00, 8, 0, 0, 0, 8'h00);

    do_reset(0, 0);
    do_reset(0, 0);

    for (int i = 0; i < NVEC; i++) begin
      cycle(tbl[i].w, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_count", i), int'(cnt_r), tbl[i].cnt);
      chk($sformatf("tbl%0d_overflow", i), int'(ovf_r), int'(tbl[i].ovf));
      chk($sformatf("tbl%0d_underflow", i), int'(unf_r), int'(tbl[i].unf));
      chk($sformatf("tbl%0d_rd_valid", i), int'(rv_r), int'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("tbl%0d_data_out", i), int'(dout_r), int'(tbl[i].dout));
      if (tbl[i].cnt == 6) chk($sformatf("tbl%0d_af_at_6", i), int'(af_r), 1);
      if (tbl[i].cnt == 5) chk($sformatf("tbl%0d_af_at_5", i), int'(af_r), 0);
    end

    // Drain, then write/read pairs across several pointer wraps.
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'($urandom_range(0, 255)), 0);
      cycle(0, 8'h00, 1);
    end
    for (int i = 0; i < 80; i++)
      cycle(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));

    // Fall-through: a word written into an empty FIFO shows without r_en.
    do_reset(0, 0);
    cycle(1, 8'hA5, 0);
    chk("fwft_data_out", int'(dout_f), 32'hA5);
    chk("fwft_rd_valid", int'(rv_f), 1);
    chk("fwft_no_reg_valid", int'(rv_r), 0);
    cycle(0, 8'h00, 1);
    chk("fwft_empty_after_ack", int'(empty_f), 1);
    chk("fwft_rd_valid_after_ack", int'(rv_f), 0);

    // Reset with requests pending at count 5: data discarded, no pulses.
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h50 + i), 0);
    chk("pre_reset_count", int'(cnt_r), 5);
    do_reset(1, 1);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 1);
    chk("stale_underflow", int'(unf_r), 1);
    chk("stale_rd_valid", int'(rv_r), 0);
    chk("stale_fw_rd_valid", int'(rv_f), 0);
    cycle(1, 8'h60, 0);
    cycle(0, 8'h00, 1);
    chk("post_reset_data", int'(dout_r), 32'h60);
    cycle(0, 8'h00, 0);
    chk("post_reset_empty", int'(empty_r), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
